// File: rtl/miriscv_int_ctrl.sv
// Interrupt controller for the miriscv core. It masks the request vector with mie,
// grants one source (fixed or round-robin priority) and returns a one-hot completion on mret.
module miriscv_int_ctrl #(
    parameter int SOURCES     = 32,
    parameter int ROUND_ROBIN = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] int_req_i,
    input  logic [31:0] mie_i,
    input  logic        int_rst_i,
    output logic        int_o,
    output logic [31:0] mcause_o,
    output logic [31:0] int_fin_o
);

    localparam logic [31:0] VALID_MASK = (SOURCES >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'h1 << SOURCES) - 32'h1);
    localparam logic [5:0]  SRC_COUNT  = 6'(SOURCES);
    localparam logic [4:0]  LAST_IDX   = 5'(SOURCES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FINISH
    } state_e;

    state_e      state_q;
    logic        int_q;
    logic [31:0] mcause_q;
    logic [31:0] fin_q;
    logic [4:0]  idx_q;
    logic [4:0]  rr_ptr_q;
    logic [4:0]  rr_ptr_d;

    logic [31:0] pend;
    logic [4:0]  search_start;
    logic [5:0]  cand;
    logic        sel_valid;
    logic [4:0]  sel_idx;

    assign pend         = int_req_i & mie_i & VALID_MASK;
    assign search_start = (ROUND_ROBIN != 0) ? rr_ptr_q : 5'd0;
    assign rr_ptr_d     = (idx_q == LAST_IDX) ? 5'd0 : idx_q + 5'd1;

    // Scan SOURCES positions starting at search_start, wrapping; first pending one wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 5'd0;
        cand      = 6'd0;
        for (int k = 0; k < SOURCES; k++) begin
            cand = {1'b0, search_start} + 6'(k);
            if (cand >= SRC_COUNT) begin
                cand = cand - SRC_COUNT;
            end
            if (!sel_valid && pend[cand[4:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand[4:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            int_q    <= 1'b0;
            mcause_q <= 32'h0;
            fin_q    <= 32'h0;
            idx_q    <= 5'd0;
            rr_ptr_q <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        idx_q    <= sel_idx;
                        mcause_q <= {1'b1, 26'b0, sel_idx};
                        int_q    <= 1'b1;
                        state_q  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // The grant is owned until mret, even if the request or enable drops.
                    if (int_rst_i) begin
                        int_q   <= 1'b0;
                        fin_q   <= 32'h1 << idx_q;
                        state_q <= FINISH;
                        if (ROUND_ROBIN != 0) begin
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end
                end
                FINISH: begin
                    fin_q   <= 32'h0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign int_o     = int_q;
    assign mcause_o  = mcause_q;
    assign int_fin_o = fin_q;

endmodule
